// File: rtl/fpnew_req_arbiter.sv
// fpnew_req_arbiter: shares one FPU between NumReq requesters.
// Requests are granted round-robin and the grant is held until the FPU accepts
// the operation. The requester index is sent through the FPU as the tag, and
// results are steered back to the owning requester by that tag. A credit
// counter limits the number of operations in flight inside the FPU.
module fpnew_req_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned Width          = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned IdWidth        = $clog2(NumReq)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  // requester side, issue
  input  logic [NumReq-1:0]                   req_valid_i,
  output logic [NumReq-1:0]                   req_ready_o,
  input  logic [NumReq-1:0][2:0][Width-1:0]   req_operands_i,
  input  logic [NumReq-1:0][3:0]              req_op_i,
  input  logic [NumReq-1:0]                   req_op_mod_i,
  input  logic [NumReq-1:0][2:0]              req_rnd_mode_i,
  input  logic [NumReq-1:0][2:0]              req_src_fmt_i,
  input  logic [NumReq-1:0][2:0]              req_dst_fmt_i,
  input  logic [NumReq-1:0][1:0]              req_int_fmt_i,
  input  logic [NumReq-1:0]                   req_vectorial_i,
  // requester side, response
  output logic [NumReq-1:0]                   rsp_valid_o,
  input  logic [NumReq-1:0]                   rsp_ready_i,
  output logic [Width-1:0]                    rsp_result_o,
  output logic [4:0]                          rsp_status_o,
  // FPU side, issue
  output logic [2:0][Width-1:0]               fpu_operands_o,
  output logic [3:0]                          fpu_op_o,
  output logic                                fpu_op_mod_o,
  output logic [2:0]                          fpu_rnd_mode_o,
  output logic [2:0]                          fpu_src_fmt_o,
  output logic [2:0]                          fpu_dst_fmt_o,
  output logic [1:0]                          fpu_int_fmt_o,
  output logic                                fpu_vectorial_o,
  output logic [IdWidth-1:0]                  fpu_tag_o,
  output logic                                fpu_in_valid_o,
  input  logic                                fpu_in_ready_i,
  // FPU side, response
  input  logic [Width-1:0]                    fpu_result_i,
  input  logic [4:0]                          fpu_status_i,
  input  logic [IdWidth-1:0]                  fpu_tag_i,
  input  logic                                fpu_out_valid_i,
  output logic                                fpu_out_ready_o,
  // control
  input  logic                                flush_i,
  output logic                                fpu_flush_o,
  output logic                                busy_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e               state_q;
  logic [IdWidth-1:0]   gnt_idx_q;
  logic [IdWidth-1:0]   rr_ptr_q;
  logic [CntWidth-1:0]  cnt_q, cnt_d;

  logic                 credit_ok;
  logic                 pick_valid;
  logic [IdWidth-1:0]   pick_idx;
  logic [IdWidth-1:0]   cand;
  logic                 issue_hs;
  logic                 rsp_hs;
  logic                 tag_ok;

  // Index base+off wrapped into 0..NumReq-1 (NumReq need not be a power of two).
  function automatic logic [IdWidth-1:0] wrap_idx(input logic [IdWidth-1:0] base,
                                                  input int unsigned        off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NumReq) sum = sum - NumReq;
    return IdWidth'(sum);
  endfunction

  assign credit_ok = (cnt_q < CntWidth'(MaxOutstanding));

  // Round-robin pick: first valid requester at or after rr_ptr_q, wrapping.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = wrap_idx(rr_ptr_q, i);
      if (!pick_valid && req_valid_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Issue path: the locked requester's fields go straight to the FPU.
  // fpu_in_valid_o depends on state and flush only, never on fpu_in_ready_i.
  assign fpu_in_valid_o  = (state_q == LOCKED) && !flush_i;
  assign issue_hs        = fpu_in_valid_o && fpu_in_ready_i;
  assign fpu_tag_o       = gnt_idx_q;
  assign fpu_operands_o  = req_operands_i[gnt_idx_q];
  assign fpu_op_o        = req_op_i[gnt_idx_q];
  assign fpu_op_mod_o    = req_op_mod_i[gnt_idx_q];
  assign fpu_rnd_mode_o  = req_rnd_mode_i[gnt_idx_q];
  assign fpu_src_fmt_o   = req_src_fmt_i[gnt_idx_q];
  assign fpu_dst_fmt_o   = req_dst_fmt_i[gnt_idx_q];
  assign fpu_int_fmt_o   = req_int_fmt_i[gnt_idx_q];
  assign fpu_vectorial_o = req_vectorial_i[gnt_idx_q];

  // Accept pulse back to the granted requester on the FPU handshake.
  always_comb begin
    req_ready_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      req_ready_o[i] = issue_hs && (gnt_idx_q == IdWidth'(i));
    end
  end

  // Response steering by tag; an out-of-range tag is drained and dropped.
  always_comb begin
    rsp_valid_o     = '0;
    fpu_out_ready_o = 1'b1;
    tag_ok          = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (fpu_tag_i == IdWidth'(i)) begin
        tag_ok          = 1'b1;
        rsp_valid_o[i]  = fpu_out_valid_i && !flush_i;
        fpu_out_ready_o = rsp_ready_i[i];
      end
    end
  end

  assign rsp_result_o = fpu_result_i;
  assign rsp_status_o = fpu_status_i;
  assign rsp_hs       = fpu_out_valid_i && fpu_out_ready_o && !flush_i;

  // Credit counter: +1 per issue, -1 per returned result, cleared by flush.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({issue_hs, rsp_hs})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (flush_i) cnt_d = '0;
  end

  // Credit counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Issue FSM: pick in IDLE, hold the grant in LOCKED until the FPU accepts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      gnt_idx_q <= '0;
      rr_ptr_q  <= '0;
    end else if (flush_i) begin
      // Abandon any held grant; the round-robin position survives the flush.
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (credit_ok && pick_valid) begin
            gnt_idx_q <= pick_idx;
            state_q   <= LOCKED;
          end
        end
        LOCKED: begin
          if (fpu_in_ready_i) begin
            rr_ptr_q <= (gnt_idx_q == IdWidth'(NumReq - 1)) ? '0 : gnt_idx_q + 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = (cnt_q != '0) || (state_q == LOCKED);
  assign fpu_flush_o = flush_i;

  // Protocol checks: bad tags, credit underflow, and requester hold rules.
  a_tag_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(fpu_out_valid_i && !tag_ok));

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rsp_hs && !issue_hs && (cnt_q == '0)));

  a_grant_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == LOCKED && !fpu_in_ready_i && !flush_i)
      |=> (state_q == LOCKED) && $stable(gnt_idx_q));

  a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == LOCKED && !fpu_in_ready_i && !flush_i) |=> req_valid_i[gnt_idx_q]);

  a_credit_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= CntWidth'(MaxOutstanding));

endmodule

// File: tb/tb_fpnew_req_arbiter.sv
// Scoreboard bench for fpnew_req_arbiter: stimulus pushes expected issues and
// responses into queues; a negedge monitor pops and compares them.
module tb_fpnew_req_arbiter;

  localparam int NumReq = 4;
  localparam int Width  = 32;
  localparam int MaxOut = 8;
  localparam int IdW    = 2;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic [NumReq-1:0]                 req_valid_i;
  logic [NumReq-1:0]                 req_ready_o;
  logic [NumReq-1:0][2:0][Width-1:0] req_operands_i;
  logic [NumReq-1:0][3:0]            req_op_i;
  logic [NumReq-1:0]                 req_op_mod_i;
  logic [NumReq-1:0][2:0]            req_rnd_mode_i;
  logic [NumReq-1:0][2:0]            req_src_fmt_i;
  logic [NumReq-1:0][2:0]            req_dst_fmt_i;
  logic [NumReq-1:0][1:0]            req_int_fmt_i;
  logic [NumReq-1:0]                 req_vectorial_i;
  logic [NumReq-1:0]                 rsp_valid_o;
  logic [NumReq-1:0]                 rsp_ready_i;
  logic [Width-1:0]                  rsp_result_o;
  logic [4:0]                        rsp_status_o;
  logic [2:0][Width-1:0]             fpu_operands_o;
  logic [3:0]                        fpu_op_o;
  logic                              fpu_op_mod_o;
  logic [2:0]                        fpu_rnd_mode_o;
  logic [2:0]                        fpu_src_fmt_o;
  logic [2:0]                        fpu_dst_fmt_o;
  logic [1:0]                        fpu_int_fmt_o;
  logic                              fpu_vectorial_o;
  logic [IdW-1:0]                    fpu_tag_o;
  logic                              fpu_in_valid_o;
  logic                              fpu_in_ready_i;
  logic [Width-1:0]                  fpu_result_i;
  logic [4:0]                        fpu_status_i;
  logic [IdW-1:0]                    fpu_tag_i;
  logic                              fpu_out_valid_i;
  logic                              fpu_out_ready_o;
  logic                              flush_i;
  logic                              fpu_flush_o;
  logic                              busy_o;

  fpnew_req_arbiter #(
    .NumReq(NumReq), .Width(Width), .MaxOutstanding(MaxOut), .IdWidth(IdW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_operands_i(req_operands_i), .req_op_i(req_op_i), .req_op_mod_i(req_op_mod_i),
    .req_rnd_mode_i(req_rnd_mode_i), .req_src_fmt_i(req_src_fmt_i),
    .req_dst_fmt_i(req_dst_fmt_i), .req_int_fmt_i(req_int_fmt_i),
    .req_vectorial_i(req_vectorial_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o),
    .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o), .fpu_op_mod_o(fpu_op_mod_o),
    .fpu_rnd_mode_o(fpu_rnd_mode_o), .fpu_src_fmt_o(fpu_src_fmt_o),
    .fpu_dst_fmt_o(fpu_dst_fmt_o), .fpu_int_fmt_o(fpu_int_fmt_o),
    .fpu_vectorial_o(fpu_vectorial_o), .fpu_tag_o(fpu_tag_o),
    .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
    .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
    .flush_i(flush_i), .fpu_flush_o(fpu_flush_o), .busy_o(busy_o)
  );

  typedef struct packed {
    logic [IdW-1:0]   tag;
    logic [Width-1:0] opa;
    logic [3:0]       op;
  } iss_t;

  typedef struct packed {
    logic [NumReq-1:0] onehot;
    logic [Width-1:0]  result;
    logic [4:0]        status;
  } rsp_t;

  iss_t exp_iss[$];
  rsp_t exp_rsp[$];
  int   iss_cyc[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   issue_cnt = 0;
  int   cycle     = 0;

  always @(posedge clk_i) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Requester r always presents operand0 = A000_0000 | r<<8 | k, op = r+2.
  function automatic iss_t exp_issue(input int r);
    iss_t e;
    e.tag = IdW'(r);
    e.opa = 32'(32'hA000_0000 | (r << 8));
    e.op  = 4'(r + 2);
    return e;
  endfunction

  task automatic push_iss(input int r);
    exp_iss.push_back(exp_issue(r));
  endtask

  // Monitor: compares every issue handshake and every delivered response.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (fpu_in_valid_o && fpu_in_ready_i) begin
        if (exp_iss.size() == 0) begin
          check("issue_unexpected", fpu_tag_o, 64'hFF);
        end else begin
          iss_t e;
          e = exp_iss.pop_front();
          check("issue_tag", fpu_tag_o, e.tag);
          check("issue_opa", fpu_operands_o[0], e.opa);
          check("issue_op", fpu_op_o, e.op);
          check("issue_rnd", fpu_rnd_mode_o, 3'(e.tag));
          check("issue_req_ready", req_ready_o, 4'b0001 << e.tag);
        end
        issue_cnt++;
        iss_cyc.push_back(cycle);
      end else begin
        check("req_ready_quiet", req_ready_o, 4'b0000);
      end
      if ((|rsp_valid_o) && fpu_out_ready_o) begin
        if (exp_rsp.size() == 0) begin
          check("rsp_unexpected", rsp_valid_o, 4'b0000);
        end else begin
          rsp_t r;
          r = exp_rsp.pop_front();
          check("rsp_onehot", rsp_valid_o, r.onehot);
          check("rsp_result", rsp_result_o, r.result);
          check("rsp_status", rsp_status_o, r.status);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Wait (bounded) until the monitor has seen `target` issues.
  task automatic wait_issues(input int target, input int budget);
    int n = 0;
    while (issue_cnt < target && n < budget) begin
      @(posedge clk_i);
      n++;
    end
    check("issue_wait_timeout", issue_cnt >= target, 1'b1);
    #1;
  endtask

  task automatic issue_one(input int r);
    req_valid_i[r] = 1'b1;
    push_iss(r);
    wait_issues(issue_cnt + 1, 10);
    req_valid_i[r] = 1'b0;
  endtask

  // Present one FPU result for tag t and wait (bounded) for it to be taken.
  task automatic respond(input int t, input logic [Width-1:0] res);
    bit ok = 1'b0;
    rsp_t r;
    fpu_out_valid_i = 1'b1;
    fpu_tag_i       = IdW'(t);
    fpu_result_i    = res;
    fpu_status_i    = 5'(t + 1);
    r.onehot = 4'b0001 << t;
    r.result = res;
    r.status = 5'(t + 1);
    exp_rsp.push_back(r);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (fpu_out_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    check("rsp_handshake_timeout", ok, 1'b1);
    @(posedge clk_i);
    #1;
    fpu_out_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_cnt;
    int base_idx;
    rsp_t r;

    for (int q = 0; q < NumReq; q++) begin
      for (int k = 0; k < 3; k++) req_operands_i[q][k] = 32'(32'hA000_0000 | (q << 8) | k);
      req_op_i[q]        = 4'(q + 2);
      req_op_mod_i[q]    = 1'(q);
      req_rnd_mode_i[q]  = 3'(q);
      req_src_fmt_i[q]   = 3'(q);
      req_dst_fmt_i[q]   = 3'(q + 1);
      req_int_fmt_i[q]   = 2'(q);
      req_vectorial_i[q] = 1'b0;
    end
    req_valid_i     = '0;
    rsp_ready_i     = 4'hF;
    fpu_in_ready_i  = 1'b1;
    fpu_result_i    = '0;
    fpu_status_i    = '0;
    fpu_tag_i       = '0;
    fpu_out_valid_i = 1'b0;
    flush_i         = 1'b1;
    rst_ni          = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk_i);
    check("rst_busy", busy_o, 1'b0);
    check("rst_in_valid", fpu_in_valid_o, 1'b0);
    check("rst_req_ready", req_ready_o, 4'b0000);
    check("rst_rsp_valid", rsp_valid_o, 4'b0000);
    check("rst_flush_follow_hi", fpu_flush_o, 1'b1);
    flush_i = 1'b0;
    #1;
    check("rst_flush_follow_lo", fpu_flush_o, 1'b0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Single op from requester 2: one-cycle grant latency, then response.
    req_valid_i[2] = 1'b1;
    push_iss(2);
    @(negedge clk_i);
    check("single_idle_no_valid", fpu_in_valid_o, 1'b0);
    @(negedge clk_i);
    check("single_locked_valid", fpu_in_valid_o, 1'b1);
    check("single_busy_locked", busy_o, 1'b1);
    tick();
    req_valid_i[2] = 1'b0;
    @(negedge clk_i);
    check("single_busy_cnt1", busy_o, 1'b1);
    check("single_idle_after", fpu_in_valid_o, 1'b0);
    tick();
    respond(2, 32'h4040_0000);
    @(negedge clk_i);
    check("single_busy_cleared", busy_o, 1'b0);
    tick();

    // Fairness: rr_ptr is 3, all valid -> 3,0,1,2,3,0,1,2 at one per 2 cycles.
    base_cnt = issue_cnt;
    base_idx = iss_cyc.size();
    for (int k = 0; k < 8; k++) push_iss((3 + k) % NumReq);
    req_valid_i = 4'hF;
    wait_issues(base_cnt + 8, 40);
    if (iss_cyc.size() >= base_idx + 8) begin
      for (int k = 1; k < 8; k++)
        check("fair_interval", iss_cyc[base_idx + k] - iss_cyc[base_idx + k - 1], 2);
    end

    // Credit limit: 8 in flight, requests still valid, nothing more issues.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      check("credit_stall", fpu_in_valid_o, 1'b0);
      check("credit_busy", busy_o, 1'b1);
    end
    tick();
    push_iss(3);
    respond(3, 32'h1111_0003);
    @(negedge clk_i);
    check("credit_regrant_gap", fpu_in_valid_o, 1'b0);
    @(negedge clk_i);
    check("credit_regrant", fpu_in_valid_o, 1'b1);
    tick();
    req_valid_i = '0;

    // Out-of-order return of tag 1 under requester backpressure.
    rsp_ready_i     = 4'b1101;
    fpu_out_valid_i = 1'b1;
    fpu_tag_i       = 2'd1;
    fpu_result_i    = 32'h2222_0001;
    fpu_status_i    = 5'd2;
    r.onehot = 4'b0010;
    r.result = 32'h2222_0001;
    r.status = 5'd2;
    exp_rsp.push_back(r);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("ooo_stall_ready", fpu_out_ready_o, 1'b0);
      check("ooo_stall_valid", rsp_valid_o, 4'b0010);
      tick();
    end
    rsp_ready_i = 4'hF;
    @(negedge clk_i);
    check("ooo_release_ready", fpu_out_ready_o, 1'b1);
    tick();
    fpu_out_valid_i = 1'b0;

    // Drain down to a single op in flight (a tag-1 op).
    respond(0, 32'h3333_0000);
    respond(0, 32'h3333_0100);
    respond(2, 32'h3333_0002);
    respond(2, 32'h3333_0102);
    respond(3, 32'h3333_0003);
    respond(3, 32'h3333_0103);
    @(negedge clk_i);
    check("drain_busy_cnt1", busy_o, 1'b1);
    tick();

    // Issue and response in the same cycle at cnt=1: count stays 1.
    req_valid_i[0] = 1'b1;
    push_iss(0);
    tick();
    fpu_out_valid_i = 1'b1;
    fpu_tag_i       = 2'd1;
    fpu_result_i    = 32'h4444_0001;
    fpu_status_i    = 5'd2;
    r.onehot = 4'b0010;
    r.result = 32'h4444_0001;
    r.status = 5'd2;
    exp_rsp.push_back(r);
    @(negedge clk_i);
    check("simul_issue", fpu_in_valid_o, 1'b1);
    check("simul_rsp", fpu_out_ready_o, 1'b1);
    tick();
    req_valid_i[0]  = 1'b0;
    fpu_out_valid_i = 1'b0;
    @(negedge clk_i);
    check("simul_cnt_kept", busy_o, 1'b1);
    tick();
    respond(0, 32'h5555_0000);
    @(negedge clk_i);
    check("simul_then_empty", busy_o, 1'b0);
    tick();

    // Flush while LOCKED with three ops in flight; rr_ptr ends at 3.
    issue_one(0);
    issue_one(1);
    issue_one(2);
    fpu_in_ready_i = 1'b0;
    req_valid_i[3] = 1'b1;
    tick();
    @(negedge clk_i);
    check("flush_pre_locked", fpu_in_valid_o, 1'b1);
    tick();
    flush_i         = 1'b1;
    fpu_in_ready_i  = 1'b1;
    fpu_out_valid_i = 1'b1;
    fpu_tag_i       = 2'd0;
    @(negedge clk_i);
    check("flush_fpu_flush_hi", fpu_flush_o, 1'b1);
    check("flush_in_valid", fpu_in_valid_o, 1'b0);
    check("flush_req_ready", req_ready_o, 4'b0000);
    check("flush_rsp_valid", rsp_valid_o, 4'b0000);
    tick();
    flush_i         = 1'b0;
    req_valid_i     = '0;
    fpu_out_valid_i = 1'b0;
    @(negedge clk_i);
    check("flush_after_busy", busy_o, 1'b0);
    check("flush_after_fpu_flush", fpu_flush_o, 1'b0);
    check("flush_after_in_valid", fpu_in_valid_o, 1'b0);
    tick();

    // rr_ptr survived the flush: with 1 and 3 valid, 3 wins.
    req_valid_i = 4'b1010;
    push_iss(3);
    wait_issues(issue_cnt + 1, 10);
    req_valid_i = '0;
    respond(3, 32'h6666_0003);
    @(negedge clk_i);
    check("final_busy", busy_o, 1'b0);

    check("iss_queue_drained", 64'(exp_iss.size()), 0);
    check("rsp_queue_drained", 64'(exp_rsp.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
